// File: rtl/matrix_stream_buffer_if.sv
// Handshake and data bundle between the matrix buffer and its producer/consumer.
interface matrix_stream_buffer_if #(
    parameter int DW = 8
) ();
    logic          start;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic          inValid;
    logic [DW-1:0] inData;
    logic          inReady;
    logic          outValid;
    logic [DW-1:0] outData;
    logic          outReady;

    // Buffer side
    modport slave (
        input  start, mode, inValid, inData, outReady,
        output busy, done, inReady, outValid, outData
    );

    // Controller / producer / consumer side
    modport master (
        output start, mode, inValid, inData, outReady,
        input  busy, done, inReady, outValid, outData
    );
endinterface

// File: rtl/matrix_stream_buffer.sv
// M x N element store with a streaming controller: a load pass fills it row-major
// over a valid/ready input, a read pass replays it row- or column-major over a
// valid/ready output with a registered data stage and full backpressure.
module matrix_stream_buffer #(
    parameter int DW = 8,
    parameter int M  = 8,
    parameter int N  = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    matrix_stream_buffer_if.slave  bus
);
    localparam int MN = M * N;
    localparam int AW = (MN > 1) ? $clog2(MN) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [RW-1:0] LAST_R = RW'(M - 1);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);
    localparam logic [AW-1:0] STEP_N = AW'(N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    logic [DW-1:0] mem [MN];

    logic [1:0]    state_q, state_d;
    logic          colMaj_q, colMaj_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          issued_q, issued_d;   // every element has been read out of the RAM
    logic          outValid_q, outValid_d;
    logic [DW-1:0] outData_q;
    logic          done_q, done_d;

    logic inHs, issue, outHs, atEnd, advRm, advCm;

    assign inHs  = (state_q == LOAD) && bus.inValid;
    assign issue = (state_q == READ) && !issued_q && (!outValid_q || bus.outReady);
    assign outHs = outValid_q && bus.outReady;
    // Both orientations finish on element (M-1, N-1).
    assign atEnd = (row_q == LAST_R) && (col_q == LAST_C);
    assign advRm = inHs || (issue && !colMaj_q);
    assign advCm = issue && colMaj_q;

    // Next-state: FSM transitions, address walk and output-stage valid.
    always_comb begin
        state_d    = state_q;
        colMaj_d   = colMaj_q;
        row_d      = row_q;
        col_d      = col_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        outValid_d = outValid_q;
        done_d     = 1'b0;

        // Address walk without a multiplier: row-major steps by 1,
        // column-major steps by N and restarts at the next column's top.
        if (advRm) begin
            addr_d = addr_q + AW'(1);
            if (col_q == LAST_C) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (advCm) begin
            if (row_q == LAST_R) begin
                row_d  = '0;
                col_d  = col_q + CW'(1);
                addr_d = AW'(col_q) + AW'(1);
            end else begin
                row_d  = row_q + RW'(1);
                addr_d = addr_q + STEP_N;
            end
        end

        // Output stage: load on issue, drain when the consumer takes it, else hold.
        if (issue) begin
            outValid_d = 1'b1;
        end else if (bus.outReady) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start && bus.mode != 2'd3) begin
                    state_d  = (bus.mode == 2'd0) ? LOAD : READ;
                    colMaj_d = (bus.mode == 2'd2);
                    row_d    = '0;
                    col_d    = '0;
                    addr_d   = '0;
                    issued_d = 1'b0;
                end
            end
            LOAD: begin
                if (inHs && atEnd) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            READ: begin
                if (issue && atEnd) begin
                    issued_d = 1'b1;
                end
                // outData holds the final element once everything has issued.
                if (outHs && issued_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= IDLE;
            colMaj_q   <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            issued_q   <= 1'b0;
            outValid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            colMaj_q   <= colMaj_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            outValid_q <= outValid_d;
            done_q     <= done_d;
        end
    end

    // Registered RAM read port; only an issue changes the presented word.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            outData_q <= '0;
        end else if (issue) begin
            outData_q <= mem[addr_q];
        end
    end

    // RAM write port; contents survive reset, but a reset edge never writes.
    always_ff @(posedge clk) begin
        if (rstN && inHs) begin
            mem[addr_q] <= bus.inData;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.inReady  = (state_q == LOAD);
    assign bus.outValid = outValid_q;
    assign bus.outData  = outData_q;
endmodule

// File: doc/matrix_stream_buffer.md
# matrix_stream_buffer

Parametrised successor to the team's single-port matrix RAM: an M×N array of DW-bit elements with a streaming controller in front of it. A load pass accepts M·N elements row-major over a valid/ready input stream. A read pass replays the matrix over a valid/ready output stream, either row-major or column-major (transposed), with full backpressure. It sits between the matrix producer (loader/DMA) and the multiply datapath, which consumes operands in either orientation.

## Interface
- DW, 8, element width in bits
- M, 8, rows (≥1)
- N, 8, columns (≥1)
- AW (localparam), clog2(M·N) (minimum 1), address width
- clk  in  1  rising-edge clock
- rstN  in  1  synchronous, active-low reset
- start  in  1  single-cycle command strobe, sampled only in IDLE
- mode  in  2  command: 0 = load, 1 = read row-major, 2 = read column-major, 3 = reserved (start ignored)
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse on the final element handshake of a pass
- inValid  in  1  load-stream element valid
- inData  in  DW  load-stream element
- inReady  out  1  load-stream ready
- outValid  out  1  read-stream element valid
- outData  out  DW  read-stream element (registered RAM output)
- outReady  in  1  read-stream ready

## Operation
- Reset: a synchronous reset (rstN low at a clock edge) forces busy=0, done=0, inReady=0, outValid=0, outData=0, FSM=IDLE and all counters to 0. Memory contents are not cleared.
- FSM states: IDLE, LOAD, READ.
  - IDLE→LOAD on start with mode=0.
  - IDLE→READ on start with mode 1 or 2. The read mode is latched at start.
  - start with mode=3, or start outside IDLE, is ignored.
  - LOAD→IDLE on the handshake of element M·N−1.
  - READ→IDLE on the output handshake of element M·N−1.
- Counters: row (0..M−1), col (0..N−1) and addr (0..M·N−1). All clear on entry to LOAD or READ. No multiplier is used.
  - Row-major: col increments and addr+1. At col=N−1, col wraps to 0 and row increments.
  - Column-major: row increments and addr+N. At row=M−1, row wraps to 0, col increments, and addr = col+1.
- LOAD:
  - inReady=1 for the whole state.
  - On inValid&&inReady, mem[addr] ← inData and the row-major counters advance.
  - inValid low stalls the pass without penalty.
- READ:
  - A RAM read issues when elements remain to be issued and (!outValid || outReady).
  - The issued word lands in outData on the next edge, with outValid=1.
  - If no read issues while outReady=1, outValid clears. If outReady=0, outData and outValid hold. This gives throughput of 1 element per cycle under continuous outReady.
  - outData changes only on an issue.
- done pulses on the edge that returns the FSM to IDLE. busy falls on that same edge.
- Reset mid-pass: the pass is aborted and the FSM returns to IDLE. Elements already written remain in memory. Any pending output is discarded (outValid=0).
- inValid is ignored outside LOAD. outReady is ignored when outValid=0.

## Timing
- start at edge t: busy=1 from t+1. inReady=1 from t+1 (LOAD).
- READ, first element:
  - The first read issues in cycle t+1.
  - outValid=1 from edge t+2.
  - Start-to-first-data latency is 2 cycles.
- Sustained read: one element per cycle while outReady=1. A stall of k cycles delays the remaining elements by exactly k cycles, with none lost or duplicated.
- Minimum pass length: LOAD M·N cycles; READ M·N+1 cycles from start.
- done and busy↓: on the same edge as the last accepted handshake's register update.
- A start may be accepted in the cycle after done (back-to-back passes). There are no cross-pass bubbles beyond the 1-cycle IDLE visit.

## Test plan
- Reset: hold rstN=0 for 2 cycles with start=1, mode=1 → busy, done, inReady, outValid and outData are all 0. After release, the FSM is IDLE until a new start.
- Load + row-major read, M=2, N=3:
  - Load 10,11,12,13,14,15 with continuous inValid → done after the 6th handshake.
  - Read mode=1 with outReady=1 → outData 10,11,12,13,14,15 on consecutive cycles, first at start+2, done with 15.
- Column-major read, same contents, mode=2 → 10,13,11,14,12,15, with done on 15.
- Backpressure:
  - During the mode=1 read, drop outReady for 3 cycles while outData=12 → 12 and outValid are held.
  - 13 follows the cycle after outReady returns.
  - Total 6 handshakes, no duplicates.
- Input gaps and illegal commands:
  - Load with inValid toggling 1,0,1,0 → all 6 elements are stored in order.
  - A start with mode=3, or a start while busy, changes nothing.
- Mid-pass reset:
  - Assert rstN=0 after 2 of 6 load handshakes → IDLE with all outputs 0.
  - A following read returns the new first 2 elements followed by the prior contents of the other 4.
